// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter with bounded burst locking for the regfile write port.
// Optional RF_WR_ARB_URGENT_EN makes requester 0 urgent (preempts locks).
module rf_wr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rf_busy,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                grant_id
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]          ptr;
    logic                   lock_on;
    logic [IW-1:0]          lock_owner;
    logic [3:0]             lock_cnt;
    logic [2*NUM_REQ-1:0]   rot;
    logic                   gnt_any;
    logic [IW-1:0]          gnt_idx;
    logic                   preempt;
    logic [3:0]             cnt_n;
    int                     scan_k;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        preempt = 1'b0;
        scan_k  = 0;
        rot     = {req_valid, req_valid} >> ptr;
        // lowest rotated position wins, i.e. first valid at or after ptr
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) scan_k = k;
        end
        if (!rst && !rf_busy) begin
            if (lock_on && req_valid[lock_owner]) begin
                gnt_any = 1'b1;
                gnt_idx = lock_owner;
            end else if (req_valid != '0) begin
                gnt_any = 1'b1;
                gnt_idx = IW'((int'(ptr) + scan_k) % NUM_REQ);
            end
`ifdef RF_WR_ARB_URGENT_EN
            if (req_valid[0]) begin
                preempt = lock_on && lock_owner != '0;
                gnt_any = 1'b1;
                gnt_idx = '0;
            end
`endif
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = gnt_any && gnt_idx == IW'(k);
        end
        cnt_n = (lock_on && lock_owner == gnt_idx) ? lock_cnt + 4'd1 : 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            grant_id   <= '0;
            ptr        <= '0;
            lock_on    <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            wr_en <= gnt_any;
            if (gnt_any) begin
                wr_addr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                wr_data  <= req_data[gnt_idx*DATA_W +: DATA_W];
                grant_id <= 3'(gnt_idx);
                ptr      <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            // when not stalled, anything other than a continuing locked grant drops the lock
            if (!rf_busy) begin
                if (gnt_any && req_lock[gnt_idx] && !preempt && cnt_n != 4'(LOCK_MAX)) begin
                    lock_on    <= 1'b1;
                    lock_owner <= gnt_idx;
                    lock_cnt   <= cnt_n;
                end else begin
                    lock_on  <= 1'b0;
                    lock_cnt <= '0;
                end
            end
        end
    end

    assert property (@(posedge clk) $onehot0(req_ready));
    assert property (@(posedge clk) (req_ready & ~req_valid) == '0);
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed and randomized checks of rf_wr_arbiter against a behavioural model.
module tb_rf_wr_arbiter;
    localparam int NR = 4, AW = 3, DW = 16, LM = 4;
`ifdef RF_WR_ARB_URGENT_EN
    localparam int FAIR[8] = '{1, 2, 3, 1, 2, 3, 1, 2};
    localparam int LOCKS[8] = '{1, 1, 1, 1, 2, 3, 1, 1};
    localparam logic [NR-1:0] ALLV = 4'b1110;
    localparam logic [NR-1:0] STALL_WIN = 4'b0001;
`else
    localparam int FAIR[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    localparam int LOCKS[8] = '{1, 1, 1, 1, 2, 3, 0, 1};
    localparam logic [NR-1:0] ALLV = 4'b1111;
    localparam logic [NR-1:0] STALL_WIN = 4'b0010;
`endif

    logic clk = 0, rst = 1, rf_busy = 0;
    logic [NR-1:0] req_valid = '0, req_lock = '0, req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0] grant_id;

    int checks = 0, errors = 0;
    int m_ptr = 0, owner = -1, cnt = 0, last_win = -1;
    logic e_en = 0;
    logic [AW-1:0] e_addr = 0;
    logic [DW-1:0] e_data = 0;
    logic [2:0] e_gid = 0;
    logic armed = 0;
    logic [NR-1:0] obs_ready;
    logic [DW-1:0] rf [8];

    always #5 clk = ~clk;

    rf_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rf_busy(rf_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .grant_id(grant_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // winner by the arbitration rules: live lock owner, else first valid from ptr; urgent 0 overrides
    function automatic int model_win();
        int w = -1;
        if (rst || rf_busy) return -1;
        if (owner >= 0 && req_valid[owner]) w = owner;
        else
            for (int k = 0; k < NR; k++)
                if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
`ifdef RF_WR_ARB_URGENT_EN
        if (req_valid[0]) w = 0;
`endif
        return w;
    endfunction

    task automatic cycle();
        int w, n;
        bit pre;
        @(negedge clk);
        w = model_win();
        obs_ready = req_ready;
        chk("ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (armed) begin
            chk("wr_en", 32'(wr_en), 32'(e_en));
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
            chk("grant_id", 32'(grant_id), 32'(e_gid));
        end
        if (wr_en === 1'b1) rf[wr_addr] = wr_data;
        pre = 0;
`ifdef RF_WR_ARB_URGENT_EN
        pre = owner > 0 && w == 0;
`endif
        if (rst) begin
            m_ptr = 0; owner = -1; cnt = 0;
            e_en = 0; e_addr = 0; e_data = 0; e_gid = 0;
            armed = 1;
        end else begin
            e_en = w >= 0;
            if (w >= 0) begin
                e_addr = req_addr[w*AW +: AW];
                e_data = req_data[w*DW +: DW];
                e_gid = 3'(w);
                m_ptr = (w + 1) % NR;
            end
            if (!rf_busy) begin
                if (w >= 0 && req_lock[w] && !pre) begin
                    n = (owner == w) ? cnt + 1 : 1;
                    if (n >= LM) begin owner = -1; cnt = 0; end
                    else begin owner = w; cnt = n; end
                end else begin
                    owner = -1; cnt = 0;
                end
            end
        end
        last_win = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; req_lock = '0; rf_busy = 0;
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; req_valid = '1;
        cycle(); cycle();
        chk("rst_ready", 32'(obs_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        rst = 0;

        req_valid = 4'b0100; req_addr[2*AW +: AW] = 3'd5; req_data[2*DW +: DW] = 16'hBEEF;
        cycle();
        chk("single_ready", 32'(obs_ready), 32'b0100);
        chk("single_wr_en", 32'(wr_en), 1);
        chk("single_wr_addr", 32'(wr_addr), 5);
        chk("single_wr_data", 32'(wr_data), 32'hBEEF);
        chk("single_grant_id", 32'(grant_id), 2);
        req_valid = '0;
        cycle();
        chk("rf_reg5", 32'(rf[5]), 32'hBEEF);

        do_reset();
        req_valid = ALLV;
        for (int j = 0; j < 8; j++) begin
            req_data = {$urandom, $urandom};
            cycle();
            chk("fair_ready", 32'(obs_ready), 32'd1 << FAIR[j]);
            chk("fair_wr_en", 32'(wr_en), 1);
        end

        do_reset();
        req_valid = 4'b0001;
        cycle();
        chk("lock_pre_ready", 32'(obs_ready), 32'b0001);
        req_valid = ALLV; req_lock = 4'b0010;
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk("lock_ready", 32'(obs_ready), 32'd1 << LOCKS[j]);
        end
        req_lock = '0;

        do_reset();
        req_valid = 4'b1111;
        cycle();
        chk("stall_pre_ready", 32'(obs_ready), 32'b0001);
        rf_busy = 1;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("stall_ready", 32'(obs_ready), 0);
            chk("stall_wr_en", 32'(wr_en), 0);
        end
        rf_busy = 0;
        cycle();
        chk("stall_release_ready", 32'(obs_ready), 32'(STALL_WIN));

        do_reset();
        req_valid = 4'b0001;
        cycle();
        req_valid = ALLV; req_lock = 4'b0010;
        cycle();
        chk("midlock_first", 32'(obs_ready), 32'b0010);
        rst = 1;
        cycle();
        chk("midlock_rst_ready", 32'(obs_ready), 0);
        chk("midlock_rst_wr_en", 32'(wr_en), 0);
        rst = 0; req_valid = 4'b1111; req_lock = '0;
        cycle();
        chk("midlock_after_ready", 32'(obs_ready), 32'b0001);

`ifdef RF_WR_ARB_URGENT_EN
        do_reset();
        req_valid = 4'b0010; req_lock = 4'b0010;
        cycle();
        chk("urgent_lock", 32'(obs_ready), 32'b0010);
        req_valid = 4'b0011;
        cycle();
        chk("urgent_preempt", 32'(obs_ready), 32'b0001);
        req_valid = 4'b0010;
        cycle();
        chk("urgent_after", 32'(obs_ready), 32'b0010);
        req_lock = '0;
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (i == last_win || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            req_lock = NR'($urandom);
            rf_busy = $urandom_range(0, 6) == 0;
            rst = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
